// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// State encoding, control bundle and canned control vectors.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FLUSH
  } pctl_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } pctl_ctrl_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam pctl_ctrl_t CTRL_DEF =
    pctl_ctrl_t'(8'b11111_000);
  localparam pctl_ctrl_t CTRL_FRZ =
    pctl_ctrl_t'(8'b00000_001);
  localparam pctl_ctrl_t CTRL_RDR =
    pctl_ctrl_t'(8'b11111_110);
  localparam pctl_ctrl_t CTRL_FLS =
    pctl_ctrl_t'(8'b11111_100);
  localparam pctl_ctrl_t CTRL_LU =
    pctl_ctrl_t'(8'b00111_010);
  localparam pctl_ctrl_t CTRL_RST =
    pctl_ctrl_t'(8'b00000_111);

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/memory inputs and pipeline register controls.
// master drives the hazard side; slave is the controller.
interface pipeline_stall_ctrl_if;
  logic i_hzd_stall_n;
  logic i_br_flush;
  logic i_dmem_req;
  logic i_dmem_ack;
  logic o_pc_en;
  logic o_if_id_en;
  logic o_id_ex_en;
  logic o_ex_mem_en;
  logic o_mem_wb_en;
  logic o_if_id_flush;
  logic o_id_ex_flush;
  logic o_mem_wb_flush;

  modport master (
    output i_hzd_stall_n, i_br_flush,
    output i_dmem_req, i_dmem_ack,
    input  o_pc_en, o_if_id_en, o_id_ex_en,
    input  o_ex_mem_en, o_mem_wb_en,
    input  o_if_id_flush, o_id_ex_flush,
    input  o_mem_wb_flush
  );

  modport slave (
    input  i_hzd_stall_n, i_br_flush,
    input  i_dmem_req, i_dmem_ack,
    output o_pc_en, o_if_id_en, o_id_ex_en,
    output o_ex_mem_en, o_mem_wb_en,
    output o_if_id_flush, o_id_ex_flush,
    output o_mem_wb_flush
  );
endinterface

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear beats increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  // count events, hold at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline enable/flush controller for the 5-stage core.
// Handles load-use, redirects and data-memory waits.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  pipeline_stall_ctrl_if.slave  bus,
  input  logic                  i_cnt_clr,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt,
  output logic                  o_timeout
);

  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);

  pctl_state_e state, state_nx;
  logic        pend, pend_nx;
  logic [15:0] wcnt, wcnt_nx;
  logic        tmo_set;
  logic        inc_flush;
  logic        inc_stall;
  logic        freeze;
  pctl_ctrl_t  ctl;
  pctl_ctrl_t  out;

  assign freeze = bus.i_dmem_req & ~bus.i_dmem_ack;

  // state, pending flush and wait counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= RUN;
      pend  <= 1'b0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      wcnt  <= wcnt_nx;
    end
  end

  // next state and Mealy control outputs
  always_comb begin
    ctl       = CTRL_DEF;
    state_nx  = state;
    pend_nx   = pend;
    wcnt_nx   = wcnt;
    tmo_set   = 1'b0;
    inc_flush = 1'b0;
    unique case (state)
      RUN, FLUSH: begin
        if (freeze) begin
          ctl      = CTRL_FRZ;
          state_nx = MEM_WAIT;
          wcnt_nx  = 16'd1;
          if (state == FLUSH) pend_nx = 1'b1;
        end else if (bus.i_br_flush) begin
          ctl       = CTRL_RDR;
          state_nx  = FLUSH;
          inc_flush = 1'b1;
        end else if (state == FLUSH) begin
          ctl      = CTRL_FLS;
          state_nx = RUN;
        end else if (!bus.i_hzd_stall_n) begin
          ctl = CTRL_LU;
        end
      end
      MEM_WAIT: begin
        if (bus.i_dmem_ack || (wcnt >= TMO)) begin
          tmo_set  = ~bus.i_dmem_ack;
          state_nx = pend ? FLUSH : RUN;
          pend_nx  = 1'b0;
          wcnt_nx  = '0;
        end else begin
          ctl     = CTRL_FRZ;
          wcnt_nx = wcnt + 16'd1;
        end
      end
      default: begin
        state_nx = RUN;
        pend_nx  = 1'b0;
        wcnt_nx  = '0;
      end
    endcase
  end

  assign inc_stall = ~ctl.pc_en;
  assign out = i_rst_n ? ctl : CTRL_RST;

  assign bus.o_pc_en        = out.pc_en;
  assign bus.o_if_id_en     = out.if_id_en;
  assign bus.o_id_ex_en     = out.id_ex_en;
  assign bus.o_ex_mem_en    = out.ex_mem_en;
  assign bus.o_mem_wb_en    = out.mem_wb_en;
  assign bus.o_if_id_flush  = out.if_id_flush;
  assign bus.o_id_ex_flush  = out.id_ex_flush;
  assign bus.o_mem_wb_flush = out.mem_wb_flush;

  // sticky forced-release flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_timeout <= 1'b0;
    end else if (tmo_set) begin
      o_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (inc_stall),
    .clr   (i_cnt_clr),
    .cnt   (o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (inc_flush),
    .clr   (i_cnt_clr),
    .cnt   (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus
// random traffic against a behavioural reference model.
module tb_pipeline_stall_ctrl;

  localparam int W    = 4;
  localparam int TMO  = 4;
  localparam int MAXC = (1 << W) - 1;

  localparam logic [7:0] V_DEF = 8'b11111_000;
  localparam logic [7:0] V_FRZ = 8'b00000_001;
  localparam logic [7:0] V_RDR = 8'b11111_110;
  localparam logic [7:0] V_FLS = 8'b11111_100;
  localparam logic [7:0] V_LU  = 8'b00111_010;
  localparam logic [7:0] V_RST = 8'b00000_111;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [W-1:0] stall_cnt;
  logic [W-1:0] flush_cnt;
  logic         timeout;
  logic [7:0]   act;

  int n_chk = 0;
  int n_err = 0;

  // model state: memory wait length so far (0 = none),
  // owed squash slot, squash owed after the wait ends
  int m_wait = 0;
  bit m_owe = 0;
  bit m_res = 0;
  bit m_tmo = 0;
  int m_sc = 0;
  int m_fc = 0;
  logic [7:0] last_act;

  pipeline_stall_ctrl_if bus ();

  pipeline_stall_ctrl #(
    .CNT_W       (W),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .i_cnt_clr   (cnt_clr),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt),
    .o_timeout   (timeout)
  );

  always #5 clk = ~clk;

  assign act = {bus.o_pc_en, bus.o_if_id_en,
                bus.o_id_ex_en, bus.o_ex_mem_en,
                bus.o_mem_wb_en, bus.o_if_id_flush,
                bus.o_id_ex_flush, bus.o_mem_wb_flush};

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.i_hzd_stall_n = 1'b1;
    bus.i_br_flush    = 1'b0;
    bus.i_dmem_req    = 1'b0;
    bus.i_dmem_ack    = 1'b0;
    cnt_clr           = 1'b0;
  endtask

  // one clock: drive, predict, compare, advance
  task automatic cycle(input bit hzd_n, input bit br,
                       input bit req, input bit ack,
                       input bit clr);
    logic [7:0] e;
    int n_wait;
    bit n_owe, n_res, n_tmo, inc_f;
    int n_sc, n_fc;
    n_wait = m_wait;
    n_owe  = m_owe;
    n_res  = m_res;
    n_tmo  = m_tmo;
    inc_f  = 0;
    bus.i_hzd_stall_n = hzd_n;
    bus.i_br_flush    = br;
    bus.i_dmem_req    = req;
    bus.i_dmem_ack    = ack;
    cnt_clr           = clr;
    #3;
    if (m_wait > 0) begin
      if (ack || m_wait >= TMO) begin
        e = V_DEF;
        if (!ack) n_tmo = 1;
        n_wait = 0;
        n_owe  = m_res;
        n_res  = 0;
      end else begin
        e = V_FRZ;
        n_wait = m_wait + 1;
      end
    end else if (req && !ack) begin
      e = V_FRZ;
      n_wait = 1;
      n_res  = m_owe;
      n_owe  = 0;
    end else if (br) begin
      e = V_RDR;
      inc_f = 1;
      n_owe = 1;
    end else if (m_owe) begin
      e = V_FLS;
      n_owe = 0;
    end else if (!hzd_n) begin
      e = V_LU;
    end else begin
      e = V_DEF;
    end
    if (clr) n_sc = 0;
    else if (!e[7]) n_sc = (m_sc < MAXC) ? m_sc + 1 : MAXC;
    else n_sc = m_sc;
    if (clr) n_fc = 0;
    else if (inc_f) n_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
    else n_fc = m_fc;
    chk("ctrl", {24'd0, act}, {24'd0, e});
    chk("stall_cnt", {28'd0, stall_cnt}, m_sc);
    chk("flush_cnt", {28'd0, flush_cnt}, m_fc);
    chk("timeout", {31'd0, timeout}, {31'd0, m_tmo});
    last_act = act;
    @(posedge clk);
    #1;
    m_wait = n_wait;
    m_owe  = n_owe;
    m_res  = n_res;
    m_tmo  = n_tmo;
    m_sc   = n_sc;
    m_fc   = n_fc;
  endtask

  // asynchronous reset pulse starting off-edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_wait = 0;
    m_owe  = 0;
    m_res  = 0;
    m_tmo  = 0;
    m_sc   = 0;
    m_fc   = 0;
    chk("rst_ctrl", {24'd0, act}, {24'd0, V_RST});
    chk("rst_stall", {28'd0, stall_cnt}, 0);
    chk("rst_flush", {28'd0, flush_cnt}, 0);
    chk("rst_tmo", {31'd0, timeout}, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    #2;
    do_reset();

    // load-use: one bubble
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("lu_out", {24'd0, last_act}, 32'h3a);
    chk("lu_cnt", {28'd0, stall_cnt}, 1);
    cycle(1, 0, 0, 0, 0);

    // redirect: two squashed slots
    cycle(1, 1, 0, 0, 0);
    chk("rdr_out", {24'd0, last_act}, 32'hfe);
    cycle(1, 0, 0, 0, 0);
    chk("fls_out", {24'd0, last_act}, 32'hfc);
    cycle(1, 0, 0, 0, 0);
    chk("rdr_cnt", {28'd0, flush_cnt}, 1);

    // freeze with load-use present, ack on 4th cycle
    cycle(1, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0);
    chk("frz_out", {24'd0, last_act}, 32'h01);
    cycle(0, 0, 1, 1, 0);
    chk("rel_out", {24'd0, last_act}, 32'hf8);
    chk("frz_cnt", {28'd0, stall_cnt}, 3);
    cycle(1, 0, 0, 0, 0);

    // freeze taken from FLUSH re-enters FLUSH
    cycle(1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 1, 0);
    cycle(1, 0, 0, 0, 0);
    chk("pend_fls", {24'd0, last_act}, 32'hfc);
    cycle(1, 0, 0, 0, 0);
    chk("pend_dflt", {24'd0, last_act}, 32'hf8);
    chk("pend_cnt", {28'd0, flush_cnt}, 1);

    // timeout after 4 frozen cycles
    cycle(1, 0, 0, 0, 1);
    repeat (4) cycle(1, 0, 1, 0, 0);
    chk("tmo_frz", {24'd0, last_act}, 32'h01);
    cycle(1, 0, 1, 0, 0);
    chk("tmo_rel", {24'd0, last_act}, 32'hf8);
    chk("tmo_flag", {31'd0, timeout}, 1);
    chk("tmo_scnt", {28'd0, stall_cnt}, 4);
    repeat (3) cycle(1, 0, 0, 0, 0);
    chk("tmo_sticky", {31'd0, timeout}, 1);

    // ack together with req: no freeze
    cycle(1, 0, 1, 1, 0);
    chk("ack_same", {24'd0, last_act}, 32'hf8);
    cycle(1, 0, 0, 0, 0);

    // saturation then clear beats a stall
    cycle(1, 0, 0, 0, 1);
    repeat (17) cycle(0, 0, 0, 0, 0);
    chk("sat_hold", {28'd0, stall_cnt}, 15);
    cycle(0, 0, 0, 0, 1);
    chk("sat_clr", {28'd0, stall_cnt}, 0);

    // reset during MEM_WAIT and during FLUSH
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    do_reset();
    chk("tmo_rst", {31'd0, timeout}, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_wait", {24'd0, last_act}, 32'hf8);
    cycle(1, 1, 0, 0, 0);
    do_reset();
    cycle(1, 0, 0, 0, 0);
    chk("rst_fls", {24'd0, last_act}, 32'hf8);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 39) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
